// File: rtl/airlock_pkg.sv
// airlock_pkg
//   Shared definitions for the airlock controllers (pressurize and evacuate).
//   Holds the chamber sequencing state type, the default fill length and the
//   width of the fill/evacuate down counter, plus a helper that turns a cycle
//   count into the value the down counter is loaded with.
//   No ports (package).
`timescale 1ns/1ps

package airlock_pkg;

  // Default number of cycles the fill valve stays open for one fill.
  localparam int FILL_CYCLES_DEFAULT = 6;

  // Width of the sequencing down counter; legal cycle counts are 1..15.
  localparam int CNT_W = 4;

  // Sequencing states shared by both chamber controllers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } airlockStateT;

  // The counter is loaded on the accepting edge and the sequence finishes on
  // the edge that sees zero, so an N-cycle phase loads N-1.
  function automatic logic [CNT_W-1:0] fillLoadValue(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/fill_timer.sv
// fill_timer
//   Down counter that times the fill phase of the pressurize controller.
//   The count saturates at zero and is only changed by load or enable.
//   Ports:
//     Clock      in   system clock, rising edge
//     Reset      in   asynchronous active-high reset, clears the count
//     load       in   load loadValue into the counter (has priority)
//     loadValue  in   CNT_W-bit value to load
//     enable     in   decrement by one this cycle (stops at zero)
//     zero       out  count is zero
`timescale 1ns/1ps

module fill_timer
  import airlock_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Counter register: a load restarts the timer, otherwise it counts down
  // while enabled and parks at zero instead of wrapping to all-ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pressurize_ctrl.sv
// pressurize_ctrl
//   Airlock repressurization sequencer. A level request with both doors
//   closed opens the fill valve for FILL_CYCLES cycles, after which the
//   chamber is reported pressurized until a door opens. A request with a door
//   open, or a door opening mid-fill, raises Abort.
//   Configuration macro: PRESSURIZE_ABORT_LATCH_EN
//     defined   - ABORT holds until the request drops and both doors close
//     undefined - ABORT lasts a single cycle, then back to IDLE
//   Ports:
//     Clock             in   system clock, rising edge
//     Reset             in   asynchronous active-high reset
//     begin_Pressurize  in   level request to repressurize
//     InnerClosed       in   1 = inner door closed
//     OuterClosed       in   1 = outer door closed
//     FillValve         out  1 = air fill valve open
//     Busy              out  1 = fill sequence in progress
//     Pressurized       out  1 = chamber at pressure
//     Abort             out  1 = request refused or fill interrupted
`timescale 1ns/1ps

module pressurize_ctrl
  import airlock_pkg::*;
#(
  parameter int FILL_CYCLES = FILL_CYCLES_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic begin_Pressurize,
  input  logic InnerClosed,
  input  logic OuterClosed,
  output logic FillValve,
  output logic Busy,
  output logic Pressurized,
  output logic Abort
);

  airlockStateT state;
  airlockStateT nextState;

  logic doorsClosed;
  logic startFill;
  logic refuse;
  logic timerZero;

  logic fillNext;
  logic busyNext;
  logic pressNext;
  logic abortNext;

  assign doorsClosed = InnerClosed && OuterClosed;
  assign startFill   = (state == IDLE) && begin_Pressurize && doorsClosed;
  assign refuse      = (state == IDLE) && begin_Pressurize && !doorsClosed;

  fill_timer u_fill_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (startFill),
    .loadValue (fillLoadValue(FILL_CYCLES)),
    .enable    (state == FILL),
    .zero      (timerZero)
  );

  // State register. The outputs are registered alongside the state so they
  // carry no combinational path from the inputs, and reset clears them
  // immediately, which shuts the fill valve without waiting for a clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      FillValve   <= 1'b0;
      Busy        <= 1'b0;
      Pressurized <= 1'b0;
      Abort       <= 1'b0;
    end else begin
      state       <= nextState;
      FillValve   <= fillNext;
      Busy        <= busyNext;
      Pressurized <= pressNext;
      Abort       <= abortNext;
    end
  end

  // Next-state logic. During FILL a door opening is checked before the timer
  // so that a door opening on the final fill edge still aborts.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startFill) begin
          nextState = FILL;
        end
      end
      FILL: begin
        if (!doorsClosed) begin
          nextState = ABORT;
        end else if (timerZero) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (!doorsClosed) begin
          nextState = IDLE;
        end
      end
      ABORT: begin
`ifdef PRESSURIZE_ABORT_LATCH_EN
        if (!begin_Pressurize && doorsClosed) begin
          nextState = IDLE;
        end
`else
        nextState = IDLE;
`endif
      end
      default: nextState = IDLE;
    endcase
  end

  // Output decode of the state being entered. A refused request leaves the
  // machine in IDLE but still flags Abort for the following cycle.
  always_comb begin
    fillNext  = 1'b0;
    busyNext  = 1'b0;
    pressNext = 1'b0;
    abortNext = 1'b0;
    case (nextState)
      FILL: begin
        fillNext = 1'b1;
        busyNext = 1'b1;
      end
      DONE:    pressNext = 1'b1;
      ABORT:   abortNext = 1'b1;
      IDLE:    abortNext = refuse;
      default: abortNext = 1'b0;
    endcase
  end

endmodule

// File: doc/pressurize_ctrl.md
PRESSURIZE_CTRL -- requirements
Module: pressurize_ctrl

Interface
REQ-001 Parameter: FILL_CYCLES, 6, number of clock cycles FillValve stays open for one fill (legal 1..15).
REQ-002 Port: Clock  input  1  single system clock, all state updates on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: begin_Pressurize  input  1  level request to repressurize the chamber.
REQ-005 Port: InnerClosed  input  1  1 = inner door closed.
REQ-006 Port: OuterClosed  input  1  1 = outer door closed.
REQ-007 Port: FillValve  output  1  1 = air fill valve open.
REQ-008 Port: Busy  output  1  1 = fill sequence in progress.
REQ-009 Port: Pressurized  output  1  1 = chamber at pressure, doors may open.
REQ-010 Port: Abort  output  1  1 = request refused or fill interrupted by a door opening.

Function
REQ-011 All outputs SHALL be registered, driven from state only; no input-to-output combinational path.
REQ-012 States SHALL be IDLE, FILL, DONE, ABORT.
REQ-013 IDLE: all outputs 0; begin_Pressurize=1 with both doors closed -> FILL, fill counter loaded with FILL_CYCLES-1.
REQ-014 IDLE: begin_Pressurize=1 with either door open -> state stays IDLE, Abort=1 for exactly the next cycle.
REQ-015 FILL: FillValve=1, Busy=1; counter decrements by 1 each cycle; counter==0 with both doors closed -> DONE.
REQ-016 Latency: begin sampled at edge k -> FillValve=1 from edge k to edge k+FILL_CYCLES; Pressurized=1 from edge k+FILL_CYCLES.
REQ-017 FILL: either door open at a sampled edge -> ABORT, FillValve=0 next cycle; door opening SHALL win over counter reaching 0 on the same edge.
REQ-018 DONE: Pressurized=1, others 0; begin_Pressurize ignored; either door open -> IDLE.
REQ-019 ABORT: Abort=1, others 0; exit behaviour per REQ-025/REQ-026.
REQ-020 Counter SHALL be 4 bits unsigned, never wraps below 0; it is held in all states except FILL.

Reset
REQ-021 Reset=1 SHALL force IDLE, counter 0, and all outputs 0 immediately, without waiting for Clock.
REQ-022 Reset asserted mid-FILL SHALL close FillValve asynchronously; after release the block is in IDLE and requires a fresh begin_Pressurize sample.
REQ-023 First state transition after reset release SHALL occur no earlier than the first rising Clock edge with Reset=0.

Configuration
REQ-024 Macro PRESSURIZE_ABORT_LATCH_EN SHALL select abort handling.
REQ-025 With PRESSURIZE_ABORT_LATCH_EN defined: ABORT SHALL hold until begin_Pressurize=0 and both doors closed at a sampled edge, then -> IDLE.
REQ-026 Without PRESSURIZE_ABORT_LATCH_EN: ABORT SHALL last exactly one cycle, then -> IDLE unconditionally.

Structure
REQ-027 Shared package airlock_pkg SHALL hold the state enum typedef, default FILL_CYCLES constant and counter width constant (4), shared with the evacuation controller.
REQ-028 One sub-module fill_timer SHALL implement the down counter (load, enable, zero flag); FSM stays in pressurize_ctrl.

Verification (bench uses FILL_CYCLES=4, period 2)
REQ-029 Reset=1 two cycles, release, doors closed, begin=1 at edge 3 -> FillValve=1 edges 3..7, Busy=1 same, Pressurized=1 from edge 7.
REQ-030 In DONE, begin held 1, InnerClosed -> 0 -> Pressurized=0 and IDLE next cycle; no new fill while InnerClosed=0.
REQ-031 IDLE, OuterClosed=0, begin=1 -> FillValve stays 0, Abort=1 one cycle.
REQ-032 FILL cycle 2, InnerClosed -> 0 -> FillValve=0 and Abort=1 next cycle; with latch macro Abort held until begin=0 and doors closed, without macro Abort lasts one cycle.
REQ-033 Door opens on same edge counter hits 0 -> ABORT, Pressurized never 1.
REQ-034 Reset=1 mid-FILL between clock edges -> FillValve=0 before next rising edge; after release with begin=1, full 4-cycle fill restarts.
